// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller.
package seg_pkg;

    localparam int NDIG  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 20;

    localparam logic [NDIG-1:0] AN_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_st_t;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [NDIG-1:0] an_sel(input logic [IDX_W-1:0] idx);
        an_sel = ~(NDIG'(1) << idx);
    endfunction

endpackage

// File: rtl/decoder.sv
// Hex nibble to active-low seven-segment pattern, y = {g,f,e,d,c,b,a}.
module decoder (
    input  logic [3:0] x,
    output logic [6:0] y
);

    // Pure lookup table from nibble to segment pattern.
    always_comb begin
        y = 7'h7F;
        case (x)
            4'h0: y = 7'b1000000;
            4'h1: y = 7'b1111001;
            4'h2: y = 7'b0100100;
            4'h3: y = 7'b0110000;
            4'h4: y = 7'b0011001;
            4'h5: y = 7'b0010010;
            4'h6: y = 7'b0000010;
            4'h7: y = 7'b1111000;
            4'h8: y = 7'b0000000;
            4'h9: y = 7'b0010000;
            4'hA: y = 7'b0001000;
            4'hB: y = 7'b0000011;
            4'hC: y = 7'b1000110;
            4'hD: y = 7'b0100001;
            4'hE: y = 7'b0000110;
            4'hF: y = 7'b0001110;
            default: y = 7'h7F;
        endcase
    end

endmodule

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and wraps; hold forces the count to 0.
module scan_prescaler
    import seg_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    // Wrap is only meaningful while counting, never while parked.
    assign wrap = !hold && (cnt == LAST);

    // Free-running slot counter, cleared while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hold || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with double-buffered digit image.
// New images become visible only at frame boundaries (or when the scanner
// is switched off), so a half-updated frame is never displayed.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 16
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             EN,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [IDX_W-1:0] WR_IDX,
    input  logic [3:0]       WR_DATA,
    input  logic             WR_DP,
    input  logic             WR_DEN,
    input  logic             COMMIT,
    output logic             PENDING,
    output logic             FRAME,
    output logic [NDIG-1:0]  AN,
    output logic [6:0]       HEX,
    output logic             DP
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    scan_st_t               st, st_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [CNT_W-1:0]       cnt;
    logic                   wrap, hold;

    logic [NDIG-1:0][3:0]   sh_nib, ac_nib, vw_nib;
    logic [NDIG-1:0]        sh_dp, sh_den, ac_dp, ac_den, vw_dp, vw_den;

    logic                   pend;
    logic                   wr_xfer, commit_ok, frame_nx, off_entry, swap;
    logic [NDIG-1:0]        an_nx, an_q;
    logic                   dp_nx, dp_q, frame_q;
    logic [3:0]             nib_nx, nib_q;

    assign wr_xfer   = WR_VALID && !pend;
    assign commit_ok = COMMIT && !pend;
    assign off_entry = !EN && (st != ST_OFF);
    // A swap needs an outstanding commit and a frame start or shutdown.
    assign swap      = pend && (frame_nx || off_entry);
    assign hold      = (st == ST_OFF) || !EN;

    assign WR_READY = !pend;
    assign PENDING  = pend;
    assign FRAME    = frame_q;
    assign AN       = an_q;
    assign DP       = dp_q;

    scan_prescaler #(.DIV(DIV)) u_presc (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .hold  (hold),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    decoder u_dec (
        .x (nib_q),
        .y (HEX)
    );

    // Scanner state and digit index register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            st  <= ST_OFF;
            idx <= '0;
        end else begin
            st  <= st_nx;
            idx <= idx_nx;
        end
    end

    // Next state, next digit index and frame-start detection.
    always_comb begin
        st_nx    = st;
        idx_nx   = idx;
        frame_nx = 1'b0;
        if (!EN) begin
            st_nx  = ST_OFF;
            idx_nx = '0;
        end else begin
            case (st)
                ST_OFF: begin
                    st_nx    = ST_BLANK;
                    idx_nx   = '0;
                    frame_nx = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) st_nx = ST_SHOW;
                end
                ST_SHOW: begin
                    if (wrap) begin
                        st_nx    = ST_BLANK;
                        idx_nx   = idx + 1'b1;
                        frame_nx = (idx == IDX_W'(NDIG - 1));
                    end
                end
                default: begin
                    st_nx  = ST_OFF;
                    idx_nx = '0;
                end
            endcase
        end
    end

    // Next output values, taken from the image that is active after this edge.
    always_comb begin
        vw_nib = swap ? sh_nib : ac_nib;
        vw_dp  = swap ? sh_dp  : ac_dp;
        vw_den = swap ? sh_den : ac_den;
        an_nx  = AN_OFF;
        dp_nx  = 1'b1;
        if (st_nx == ST_SHOW) begin
            if (vw_den[idx_nx]) an_nx = an_sel(idx_nx);
            dp_nx = !vw_dp[idx_nx];
        end
        nib_nx = vw_nib[idx_nx];
    end

    // Registered pin drivers and the decoder input nibble.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            an_q    <= AN_OFF;
            dp_q    <= 1'b1;
            nib_q   <= 4'h0;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_nx;
            dp_q    <= dp_nx;
            nib_q   <= nib_nx;
            frame_q <= frame_nx;
        end
    end

    // Commit handshake: set by an accepted commit, cleared by the swap.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend <= 1'b0;
        end else if (swap) begin
            pend <= 1'b0;
        end else if (commit_ok) begin
            pend <= 1'b1;
        end
    end

    // Shadow image written by the producer while no commit is outstanding.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sh_nib <= '0;
            sh_dp  <= '0;
            sh_den <= '0;
        end else if (wr_xfer) begin
            sh_nib[WR_IDX] <= WR_DATA;
            sh_dp[WR_IDX]  <= WR_DP;
            sh_den[WR_IDX] <= WR_DEN;
        end
    end

    // Active image, replaced wholesale on a swap.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ac_nib <= '0;
            ac_dp  <= '0;
            ac_den <= '0;
        end else if (swap) begin
            ac_nib <= sh_nib;
            ac_dp  <= sh_dp;
            ac_den <= sh_den;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8, BLANK=2.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_den;
    logic       commit;
    logic       pending;
    logic       frame;
    logic [7:0] an;
    logic [6:0] hex;
    logic       dp;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .EN         (en),
        .WR_VALID   (wr_valid),
        .WR_READY   (wr_ready),
        .WR_IDX     (wr_idx),
        .WR_DATA    (wr_data),
        .WR_DP      (wr_dp),
        .WR_DEN     (wr_den),
        .COMMIT     (commit),
        .PENDING    (pending),
        .FRAME      (frame),
        .AN         (an),
        .HEX        (hex),
        .DP         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference seven-segment table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] i, input logic [3:0] d, input logic p,
                      input logic e, input logic c);
        wr_valid = 1'b1;
        wr_idx   = i;
        wr_data  = d;
        wr_dp    = p;
        wr_den   = e;
        commit   = c;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frame !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", {31'd0, frame}, 32'd1);
    endtask

    // Check one full frame; entered at cycle 0 of slot 0, leaves at next frame start.
    task automatic scan_frame(input logic [7:0] den, input logic [7:0] dpm, input logic [31:0] nibs);
        logic [7:0] e_an;
        logic       e_dp;
        logic       e_fr;
        logic [3:0] nb;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 8; c++) begin
                nb   = nibs[k*4 +: 4];
                e_an = 8'hFF;
                if (c >= 2 && den[k]) e_an = ~(8'd1 << k);
                e_dp = (c >= 2 && dpm[k]) ? 1'b0 : 1'b1;
                e_fr = (k == 0 && c == 0);
                chk($sformatf("scan_an k%0d c%0d", k, c), {24'd0, an}, {24'd0, e_an});
                chk($sformatf("scan_dp k%0d c%0d", k, c), {31'd0, dp}, {31'd0, e_dp});
                chk($sformatf("scan_hex k%0d c%0d", k, c), {25'd0, hex}, {25'd0, seg(nb)});
                chk($sformatf("scan_frame k%0d c%0d", k, c), {31'd0, frame}, {31'd0, e_fr});
                step(1);
            end
        end
        chk("frame_len", {31'd0, frame}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = 3'd0;
        wr_data  = 4'h0;
        wr_dp    = 1'b0;
        wr_den   = 1'b0;
        commit   = 1'b0;
        step(2);

        // Reset state
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_hex", {25'd0, hex}, 32'h40);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic frame: digits 0..7, all enabled
        for (int k = 0; k < 8; k++) wr(3'(k), 4'(k), 1'b0, 1'b1, 1'b0);
        pulse_commit();
        chk("t1_pending", {31'd0, pending}, 32'd1);
        chk("t1_ready", {31'd0, wr_ready}, 32'd0);
        chk("t1_off_an", {24'd0, an}, 32'hFF);
        chk("t1_off_frame", {31'd0, frame}, 32'd0);
        en = 1'b1;
        step(1);
        chk("t1_frame", {31'd0, frame}, 32'd1);
        chk("t1_pend_clr", {31'd0, pending}, 32'd0);
        scan_frame(8'hFF, 8'h00, 32'h76543210);

        // Odd digits enabled, DP on digit 3
        for (int k = 0; k < 8; k++) wr(3'(k), 4'(k), (k == 3), k[0], 1'b0);
        pulse_commit();
        chk("t2_pending", {31'd0, pending}, 32'd1);
        wait_frame();
        chk("t2_pend_clr", {31'd0, pending}, 32'd0);
        scan_frame(8'hAA, 8'h08, 32'h76543210);

        // Commit mid-frame only shows in the next frame
        step(16);
        wr(3'd5, 4'h9, 1'b0, 1'b1, 1'b0);
        wr(3'd4, 4'h4, 1'b0, 1'b1, 1'b0);
        pulse_commit();
        wr(3'd6, 4'hF, 1'b0, 1'b1, 1'b0);
        chk("t3_pending", {31'd0, pending}, 32'd1);
        chk("t3_ready", {31'd0, wr_ready}, 32'd0);
        step(24);
        chk("t3_old_hex", {25'd0, hex}, {25'd0, seg(4'h5)});
        chk("t3_old_an", {24'd0, an}, 32'hDF);
        chk("t3_ready_hold", {31'd0, wr_ready}, 32'd0);
        wait_frame();
        chk("t3_pend_clr", {31'd0, pending}, 32'd0);
        chk("t3_ready_back", {31'd0, wr_ready}, 32'd1);
        step(44);
        chk("t3_new_hex", {25'd0, hex}, {25'd0, seg(4'h9)});
        chk("t3_new_an", {24'd0, an}, 32'hDF);
        step(8);
        chk("t3_rej_hex", {25'd0, hex}, {25'd0, seg(4'h6)});
        chk("t3_rej_an", {24'd0, an}, 32'hFF);

        // Write and commit in the same cycle; repeat commit while pending
        wr(3'd0, 4'hA, 1'b0, 1'b1, 1'b1);
        chk("t4_pending", {31'd0, pending}, 32'd1);
        chk("t4_ready", {31'd0, wr_ready}, 32'd0);
        pulse_commit();
        wait_frame();
        chk("t4_hex_a", {25'd0, hex}, {25'd0, seg(4'hA)});
        chk("t4_pend_clr", {31'd0, pending}, 32'd0);
        step(1);
        chk("t4_no_repend", {31'd0, pending}, 32'd0);
        wr(3'd0, 4'h3, 1'b0, 1'b1, 1'b0);
        step(62);
        chk("t4_frame2", {31'd0, frame}, 32'd1);
        chk("t4_no_swap", {25'd0, hex}, {25'd0, seg(4'hA)});

        // EN drop in slot 4 SHOW applies the pending commit
        pulse_commit();
        chk("t5_pending", {31'd0, pending}, 32'd1);
        step(34);
        chk("t5_an4", {24'd0, an}, 32'hEF);
        chk("t5_hex4", {25'd0, hex}, {25'd0, seg(4'h4)});
        en = 1'b0;
        step(1);
        chk("t5_off_an", {24'd0, an}, 32'hFF);
        chk("t5_off_dp", {31'd0, dp}, 32'd1);
        chk("t5_off_pend", {31'd0, pending}, 32'd0);
        chk("t5_off_ready", {31'd0, wr_ready}, 32'd1);
        chk("t5_off_hex", {25'd0, hex}, {25'd0, seg(4'h3)});
        chk("t5_off_frame", {31'd0, frame}, 32'd0);
        step(3);
        chk("t5_park_an", {24'd0, an}, 32'hFF);
        chk("t5_park_frame", {31'd0, frame}, 32'd0);
        en = 1'b1;
        step(1);
        chk("t5_on_frame", {31'd0, frame}, 32'd1);
        chk("t5_on_an", {24'd0, an}, 32'hFF);
        chk("t5_on_hex", {25'd0, hex}, {25'd0, seg(4'h3)});
        step(2);
        chk("t5_show0", {24'd0, an}, 32'hFE);

        // Asynchronous reset mid-slot
        step(3);
        pulse_commit();
        chk("t6_pending", {31'd0, pending}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_an", {24'd0, an}, 32'hFF);
        chk("t6_dp", {31'd0, dp}, 32'd1);
        chk("t6_pend", {31'd0, pending}, 32'd0);
        chk("t6_ready", {31'd0, wr_ready}, 32'd1);
        chk("t6_hex", {25'd0, hex}, 32'h40);
        chk("t6_frame", {31'd0, frame}, 32'd0);
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("t6_off_an", {24'd0, an}, 32'hFF);
        chk("t6_off_frame", {31'd0, frame}, 32'd0);
        en = 1'b1;
        step(1);
        chk("t6_on_frame", {31'd0, frame}, 32'd1);
        chk("t6_on_hex", {25'd0, hex}, 32'h40);
        step(2);
        chk("t6_img_clr", {24'd0, an}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit 7-segment display. One shared `decoder` is driven with one digit nibble at a time. The block holds a double-buffered 8×4-bit digit image plus per-digit decimal-point and enable masks. It sequences AN/HEX/DP with a blanking gap between digits, and swaps in new images only at frame boundaries so the display never tears. It sits between the switch/datapath logic (writer) and the board pins AN, HEX, DP.

## Interface
- DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 4..2^20.
- BLANK, 16: cycles at slot start with all anodes off; legal range 1..DIV-2.
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  reset, asynchronous and active-low.
- EN  in  1  scan enable; 0 = display dark and scanner parked.
- WR_VALID  in  1  write request into the shadow image.
- WR_READY  out  1  shadow accepts writes; reset 1.
- WR_IDX  in  3  digit index 0..7.
- WR_DATA  in  4  digit nibble.
- WR_DP  in  1  decimal point for WR_IDX, 1 = lit.
- WR_DEN  in  1  digit enable for WR_IDX, 1 = shown.
- COMMIT  in  1  single-cycle pulse requesting a shadow→active swap.
- PENDING  out  1  commit accepted, not yet applied; reset 0.
- FRAME  out  1  one-cycle pulse when slot 0 begins; reset 0.
- AN  out  8  anodes, active-low; reset 8'hFF.
- HEX  out  7  segments from the `decoder` instance, active-low; reset = decoder(4'h0).
- DP  out  1  decimal point, active-low; reset 1.

## Operation
- Storage: shadow and active images, each with 8 nibbles, 8 DP bits and 8 DEN bits. All reset to 0.
- Write: a transfer occurs when WR_VALID && WR_READY. It updates the shadow entry at WR_IDX.
- WR_READY = !PENDING.
- COMMIT when !PENDING sets PENDING. COMMIT while PENDING is ignored.
- WR transfer and COMMIT in the same cycle: the write lands in the shadow before the swap, so it is included in the commit.
- Swap: active ← shadow on the cycle FRAME is asserted, or on entry to OFF. PENDING clears on that same edge.
- FSM states:
  - OFF: AN=FF, DP=1, prescaler=0, idx=0.
  - BLANK: AN=FF; the decoder input already carries the nibble for idx.
  - SHOW: AN[idx]=0 if DEN[idx], else AN=FF; DP=!DP_active[idx].
- Transitions:
  - Reset → OFF.
  - OFF → BLANK when EN=1, with idx=0 and FRAME pulsed.
  - BLANK → SHOW when prescaler = BLANK-1.
  - SHOW → BLANK when prescaler = DIV-1: prescaler wraps to 0 and idx increments mod 8. FRAME pulses when idx wraps 7→0.
  - Any state → OFF when EN=0. This takes effect on the next edge.
- Prescaler: 20-bit counter, 0..DIV-1, wraps. It is held at 0 in OFF.
- Decoder input is registered from active nibble[idx]. It is updated on the same edge as idx.

## Timing
- All outputs are registered, except HEX, which is combinational from the registered nibble through `decoder`.
- Each slot is exactly DIV cycles: BLANK dark cycles, then DIV-BLANK lit cycles. A full frame is 8·DIV cycles.
- Write-to-display latency: at most one frame after COMMIT, plus one cycle.
- EN falling mid-slot: AN=FF on the next cycle, and any pending commit is applied on that edge.
- EN rising: the first FRAME pulse and slot 0 blanking start on the next edge.
- Asynchronous reset mid-frame clears everything immediately. The scanner restarts in OFF with both images zeroed.

## Structure
- Shared package `seg_pkg`:
  - NDIG=8.
  - digit index width 3.
  - FSM state encoding (OFF/BLANK/SHOW).
  - AN_OFF=8'hFF.
- Sub-modules:
  - Reuses the existing `decoder` (x[3:0] → y[6:0]).
  - One new sub-module, `scan_prescaler`: parameter DIV; outputs the count and a wrap pulse; has a synchronous hold input.

## Test plan
DIV=8, BLANK=2 unless noted.
- Reset then EN=1, shadow = 0x76543210 with DEN=FF, COMMIT → PENDING clears at the FRAME pulse. Slot k shows AN with bit k low for cycles 2..7 and HEX = decoder(k). AN=FF for cycles 0..1. Frame length is 64 cycles.
- With DEN=8'b1010_1010, even slots are dark for the whole slot. DP bit 3 set → DP=0 only during slot 3 SHOW.
- Write nibble 9 to idx 5 and COMMIT during slot 2 → slot 5 of the current frame still shows the old value; 9 appears in slot 5 of the next frame. WR_READY is 0 from COMMIT until the swap.
- WR_VALID and COMMIT in the same cycle (idx 0, data A) → the transfer is accepted and A is shown in the next frame's slot 0. A second COMMIT while PENDING causes no extra swap.
- EN=0 during slot 4 SHOW → AN=FF the next cycle and the pending commit is applied. EN=1 → FRAME pulses and slot 0 blanking begins.
- Assert CPU_RESETN=0 asynchronously mid-slot → outputs go to AN=FF, DP=1, PENDING=0, WR_READY=1 immediately; after release the state is OFF.
